// File: rtl/npc_ras_unit.sv
// Next-PC unit: architectural PC, MIPS branch/jump target selection, exception redirect,
// and a circular return-address stack that scores every `jr $ra` against its prediction.
module npc_ras_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          RAS_DEPTH  = 4,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc,
    input  logic [3:0]       op,
    input  logic             zero,
    input  logic             gez,
    input  logic [25:0]      imm,
    input  logic [31:0]      reg_data,
    input  logic             is_ret,
    output logic [31:0]      pc,
    output logic [31:0]      pcplus4,
    output logic [31:0]      npc,
    output logic [31:0]      ras_top,
    output logic             ras_empty,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0]      DEPTH_C = (PW+1)'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [3:0] {
        OP_PLUS4 = 4'd0,
        OP_BEQ   = 4'd1,
        OP_BNE   = 4'd2,
        OP_BGEZ  = 4'd3,
        OP_BGTZ  = 4'd4,
        OP_BLEZ  = 4'd5,
        OP_BLTZ  = 4'd6,
        OP_J     = 4'd7,
        OP_JAL   = 4'd8,
        OP_JR    = 4'd9,
        OP_JALR  = 4'd10
    } op_e;

    logic [31:0]      pc_reg;
    logic [PW-1:0]    ptr_reg;
    logic [PW:0]      count_reg;
    logic [31:0]      entry_reg [RAS_DEPTH];
    logic [CNT_W-1:0] ret_cnt_reg;
    logic [CNT_W-1:0] mispred_cnt_reg;

    logic [31:0]   branch_target;
    logic [31:0]   jump_target;
    logic [PW-1:0] ptr_dec;
    logic          advance;
    logic          do_push;
    logic          do_pop;
    logic          pop_miss;

    assign pcplus4       = pc_reg + 32'd4;
    assign branch_target = pcplus4 + {{14{imm[15]}}, imm[15:0], 2'b00};
    assign jump_target   = {pcplus4[31:28], imm, 2'b00};
    assign ptr_dec       = ptr_reg - PW'(1);

    // Exceptions pre-empt the architectural effects of the current instruction.
    assign advance  = !stall && !exc;
    assign do_push  = advance && (op == OP_JAL || op == OP_JALR);
    assign do_pop   = advance && (op == OP_JR) && is_ret;
    assign pop_miss = (count_reg == '0) || (entry_reg[ptr_dec] != reg_data);

    always_comb begin
        npc = pcplus4;
        case (op)
            OP_BEQ:          if (zero)         npc = branch_target;
            OP_BNE:          if (!zero)        npc = branch_target;
            OP_BGEZ:         if (gez)          npc = branch_target;
            OP_BGTZ:         if (gez && !zero) npc = branch_target;
            OP_BLEZ:         if (zero || !gez) npc = branch_target;
            OP_BLTZ:         if (!gez)         npc = branch_target;
            OP_J, OP_JAL:    npc = jump_target;
            OP_JR, OP_JALR:  npc = reg_data;
            default:         npc = pcplus4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else if (exc) begin
            pc_reg <= EXC_VECTOR;
        end else if (!stall) begin
            pc_reg <= npc;
        end
    end

    // When full, a push lands on the oldest slot and the depth stays pinned at RAS_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else if (do_push) begin
            entry_reg[ptr_reg] <= pcplus4;
            ptr_reg            <= ptr_reg + PW'(1);
            if (count_reg != DEPTH_C) begin
                count_reg <= count_reg + (PW+1)'(1);
            end
        end else if (do_pop && count_reg != '0) begin
            ptr_reg   <= ptr_dec;
            count_reg <= count_reg - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_cnt_reg     <= '0;
            mispred_cnt_reg <= '0;
        end else if (do_pop) begin
            if (ret_cnt_reg != CNT_MAX) begin
                ret_cnt_reg <= ret_cnt_reg + CNT_W'(1);
            end
            if (pop_miss && mispred_cnt_reg != CNT_MAX) begin
                mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign pc          = pc_reg;
    assign ras_empty   = (count_reg == '0);
    assign ras_top     = ras_empty ? 32'd0 : entry_reg[ptr_dec];
    assign ret_cnt     = ret_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;

endmodule
